led_alarm_mc: RTL and testbench
===============================

# led_alarm_mc

Multi-channel LED alarm indicator. Each channel drives one status LED: solid on when healthy, and a blink pattern when its error input is active. The pattern is either continuous blinking or an N-pulse burst code followed by a pause. An optional sticky latch keeps an error visible until software clears it. The block sits at board-level status outputs, fed by per-subsystem error flags and a host clear strobe.

## Interface
- `N_CH`, default 4: number of independent LED channels (≥1).
- `HALF_PERIOD`, default 25_000_000: clk cycles per blink half-period (≥2).
- `CNT_W`, default 25: half-period counter width; must satisfy `HALF_PERIOD-1 < 2^CNT_W`.
- `CODE_W`, default 4: width of each channel's burst code.
- `GAP_HALVES`, default 4: pause length in half-periods between bursts; must satisfy `1 ≤ GAP_HALVES ≤ 2^CODE_W-1`.
- `STICKY`, default 0: 1 latches errors until cleared; 0 follows `error_flag` live.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `error_flag`  in  N_CH: per-channel error level.
- `err_code`  in  N_CH*CODE_W: channel i code at bits [i*CODE_W +: CODE_W]; 0 selects continuous blink.
- `clr`  in  1: single-cycle clear of all sticky latches.
- `led`  out  N_CH: LED drive, 1 = on; registered.
- `err_latched`  out  N_CH: sticky latch state; constant 0 when STICKY=0.
- `any_err`  out  1: OR of all channel `active` signals; registered.

## Operation
- `active[i]` = `error_flag[i] | (STICKY & err_latched[i])`.
- Latch, per channel:
  - Set when `error_flag[i]` is 1.
  - Cleared when `clr` is 1 and `error_flag[i]` is 0.
  - If set and clear coincide, set wins.
- Per-channel FSM, states IDLE / MARK / SPACE / GAP.
  - LED levels: IDLE=1, MARK=1, SPACE=0, GAP=1.
  - Registers per channel: state, half counter `cnt`, pulse/gap counter `pc`, latched code `code_q`.
- Transitions:
  - IDLE, when `active`: go to MARK with `cnt=0`, `pc=0`, `code_q=err_code[i]`.
  - MARK, when `cnt==HALF_PERIOD-1`: go to SPACE with `cnt=0`.
  - SPACE, when `cnt==HALF_PERIOD-1`:
    - If `code_q==0` or `pc+1<code_q`: go to MARK with `pc=pc+1` (pc saturates; irrelevant when code_q=0).
    - Otherwise: go to GAP with `pc=0`.
  - GAP: each time `cnt==HALF_PERIOD-1`, increment `pc`. When `pc==GAP_HALVES-1` at that point, go to MARK with `pc=0`, `cnt=0`, and `code_q` re-sampled.
  - Any state, when `!active`: go to IDLE next edge with `cnt=0` and `pc=0`. This has priority over all other transitions.
- Code changes mid-burst are ignored until the next burst starts (entry from IDLE or exit from GAP).
- Channels are fully independent; there is no shared phase.

## Timing
- Reset values: `led`=0, `any_err`=0, `err_latched`=0, all FSMs IDLE, all counters 0.
  - On the first edge after reset release, `led` goes to 1 on every inactive channel.
- Error activation:
  - Error sampled at edge t → MARK from t (`led` stays 1).
  - `led` falls at edge t+HALF_PERIOD.
  - With code 0, `led` toggles every HALF_PERIOD edges thereafter.
- Code k>0 burst:
  - k × (HALF_PERIOD high, HALF_PERIOD low), then GAP_HALVES×HALF_PERIOD high.
  - The next MARK follows immediately, so the high run between bursts is (GAP_HALVES+1)×HALF_PERIOD cycles.
- Deassertion: `led`=1 on the edge that samples `active`=0, i.e. 1-cycle latency from `error_flag` falling (STICKY=0).
- Latch: `err_latched` updates one edge after its `error_flag` or `clr` cause. `any_err` has the same 1-cycle latency.
- Asynchronous reset mid-pattern immediately forces all reset values.

## Structure
- Package `led_alarm_pkg`: state enum (IDLE, MARK, SPACE, GAP) and LED-level localparams (`LED_ON`=1, `LED_OFF`=0).
- Sub-module `led_alarm_ch`: one channel's FSM, counters and LED register, with parameters HALF_PERIOD, CNT_W, CODE_W and GAP_HALVES.
- Top level: sticky latches, `active` generation, generate loop over `led_alarm_ch`, and the `any_err` register.

## Test plan
All scenarios use HALF_PERIOD=4 and GAP_HALVES=3.
1. Reset, then release with all errors low → `led`=0 during reset, then 4'b1111 from the first edge; `any_err`=0.
2. Ch0 with code 0 and `error_flag[0]` held high from edge t → `led[0]` is 1 over t..t+3, 0 over t+4..t+7, 1 over t+8..t+11, and continues; other channels stay at 1.
3. Ch1 with code 2 → `led[1]` pattern 1×4, 0×4, 1×4, 0×4, then 1×16, then 0×4 …, repeating.
4. Ch0 with code 0, `error_flag` dropped mid-SPACE → `led[0]`=1 on the next edge. Reasserting restarts with a full 4-cycle high.
5. STICKY=1:
   - 1-cycle error pulse on ch2 → `err_latched[2]`=1 and blinking continues.
   - `clr` while `error_flag[2]`=1 → latch stays 1.
   - `clr` with the flag low → latch 0 and `led[2]`=1 within 2 edges.
6. Ch3 `err_code` changed from 2 to 3 during a burst → the current burst finishes with 2 pulses and the next burst has 3.

Source files
------------

// File: rtl/led_alarm_pkg.sv
// Shared types and constants for the LED alarm indicator.
// Channel FSM states and LED drive levels.
package led_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } ch_state_e;

  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;

endpackage

// File: rtl/led_alarm_ch.sv
// One LED channel: blink/burst-code FSM with its counters.
// The LED is registered and follows the level of the next state.
import led_alarm_pkg::*;

module led_alarm_ch #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int CNT_W       = 25,
  parameter int CODE_W      = 4,
  parameter int GAP_HALVES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              led_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HALF_PERIOD - 1);
  localparam logic [CODE_W-1:0] GAP_LAST =
    CODE_W'(GAP_HALVES - 1);

  ch_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] pc_q;
  logic [CODE_W-1:0] code_q;
  logic              led_q;

  logic              half_done;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CODE_W:0]   pc_nxt_w;
  logic [CODE_W-1:0] pc_sat;
  logic              more_pulses;

  // End-of-half and pulse-count helpers for the FSM below
  always_comb begin
    half_done   = (cnt_q == CNT_LAST);
    cnt_inc     = cnt_q + 1'b1;
    pc_nxt_w    = {1'b0, pc_q} + 1'b1;
    pc_sat      = (&pc_q) ? pc_q : pc_q + 1'b1;
    more_pulses = (code_q == '0) ||
                  (pc_nxt_w < {1'b0, code_q});
  end

  // Channel FSM with registered LED level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      code_q  <= '0;
      led_q   <= LED_OFF;
    end else if (!active_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      led_q   <= LED_ON;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= MARK;
          cnt_q   <= '0;
          pc_q    <= '0;
          code_q  <= code_i;
          led_q   <= LED_ON;
        end
        MARK: begin
          if (half_done) begin
            state_q <= SPACE;
            cnt_q   <= '0;
            led_q   <= LED_OFF;
          end else begin
            cnt_q   <= cnt_inc;
            led_q   <= LED_ON;
          end
        end
        SPACE: begin
          if (half_done) begin
            cnt_q <= '0;
            led_q <= LED_ON;
            if (more_pulses) begin
              state_q <= MARK;
              pc_q    <= pc_sat;
            end else begin
              state_q <= GAP;
              pc_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_inc;
            led_q <= LED_OFF;
          end
        end
        GAP: begin
          led_q <= LED_ON;
          if (half_done) begin
            cnt_q <= '0;
            if (pc_q == GAP_LAST) begin
              state_q <= MARK;
              pc_q    <= '0;
              code_q  <= code_i;
            end else begin
              pc_q    <= pc_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          pc_q    <= '0;
          led_q   <= LED_ON;
        end
      endcase
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_alarm_mc.sv
// Multi-channel LED alarm indicator top level.
// Sticky latches, per-channel activity, channel array, any_err.
import led_alarm_pkg::*;

module led_alarm_mc #(
  parameter int N_CH        = 4,
  parameter int HALF_PERIOD = 25_000_000,
  parameter int CNT_W       = 25,
  parameter int CODE_W      = 4,
  parameter int GAP_HALVES  = 4,
  parameter int STICKY      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        error_flag,
  input  logic [N_CH*CODE_W-1:0] err_code,
  input  logic                   clr,
  output logic [N_CH-1:0]        led,
  output logic [N_CH-1:0]        err_latched,
  output logic                   any_err
);

  localparam logic STK_EN = (STICKY != 0);

  logic [N_CH-1:0] latch_q;
  logic [N_CH-1:0] latch_d;
  logic [N_CH-1:0] active;
  logic            any_err_q;
  logic            any_err_d;

  // Latch next state: set beats clear; held at 0 when not sticky
  always_comb begin
    latch_d = '0;
    if (STK_EN) begin
      latch_d = error_flag | (latch_q & ~{N_CH{clr}});
    end
    active    = error_flag | (latch_q & {N_CH{STK_EN}});
    any_err_d = |active;
  end

  // Sticky latch and any_err registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= '0;
      any_err_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      any_err_q <= any_err_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_alarm_ch #(
      .HALF_PERIOD (HALF_PERIOD),
      .CNT_W       (CNT_W),
      .CODE_W      (CODE_W),
      .GAP_HALVES  (GAP_HALVES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .active_i (active[i]),
      .code_i   (err_code[i*CODE_W +: CODE_W]),
      .led_o    (led[i])
    );
  end

  assign err_latched = latch_q;
  assign any_err     = any_err_q;

endmodule

// File: tb/tb_led_alarm_mc.sv
// Directed self-checking bench for led_alarm_mc.
// Two instances: live-follow (dut0) and sticky (dut1).
module tb_led_alarm_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  f0, f1;
  logic [15:0] c0, c1;
  logic        clr0, clr1;
  logic [3:0]  led0, lat0, led1, lat1;
  logic        any0, any1;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_alarm_mc #(
    .N_CH(4), .HALF_PERIOD(4), .CNT_W(3),
    .CODE_W(4), .GAP_HALVES(3), .STICKY(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .error_flag(f0),
    .err_code(c0), .clr(clr0), .led(led0),
    .err_latched(lat0), .any_err(any0)
  );

  led_alarm_mc #(
    .N_CH(4), .HALF_PERIOD(4), .CNT_W(3),
    .CODE_W(4), .GAP_HALVES(3), .STICKY(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .error_flag(f1),
    .err_code(c1), .clr(clr1), .led(led1),
    .err_latched(lat1), .any_err(any1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic pbit(input string s, input int j);
    return s[j] == 8'h31;
  endfunction

  // Step one cycle per char and check led0[ch] against pattern
  task automatic run_pat(input string tag, input string pat,
                         input int ch);
    for (int j = 0; j < pat.len(); j++) begin
      @(negedge clk);
      chk(tag, 32'(led0[ch]), 32'(pbit(pat, j)));
    end
  endtask

  string p2, p3, p6;

  initial begin
    f0 = '0; f1 = '0; c0 = '0; c1 = '0;
    clr0 = 1'b0; clr1 = 1'b0;
    rst_n = 1'b0;

    // 1. reset and release
    repeat (2) @(negedge clk);
    chk("rst_led0", 32'(led0), 32'h0);
    chk("rst_any0", 32'(any0), 32'h0);
    chk("rst_led1", 32'(led1), 32'h0);
    chk("rst_lat1", 32'(lat1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_led0", 32'(led0), 32'hf);
    chk("rel_led1", 32'(led1), 32'hf);
    chk("rel_any0", 32'(any0), 32'h0);

    // 2. ch0 continuous blink
    c0[3:0] = 4'd0;
    f0[0] = 1'b1;
    p2 = "11110000111100";
    for (int j = 0; j < p2.len(); j++) begin
      @(negedge clk);
      chk("s2_led0", 32'(led0[0]), 32'(pbit(p2, j)));
      if (j == 0) begin
        chk("s2_any", 32'(any0), 32'h1);
        chk("s2_oth", 32'(led0[3:1]), 32'h7);
      end
    end

    // 4. drop mid-SPACE, then reassert
    f0[0] = 1'b0;
    @(negedge clk);
    chk("s4_drop", 32'(led0[0]), 32'h1);
    chk("s4_any", 32'(any0), 32'h0);
    f0[0] = 1'b1;
    run_pat("s4_rearm", "11110", 0);
    f0[0] = 1'b0;
    @(negedge clk);
    chk("s4_idle", 32'(led0), 32'hf);

    // 3. ch1 burst code 2
    c0[7:4] = 4'd2;
    f0[1] = 1'b1;
    p3 = {"1111000011110000", "1111111111111111",
          "0000111100001111"};
    run_pat("s3_led1", p3, 1);
    chk("s3_ch0", 32'(led0[0]), 32'h1);
    f0[1] = 1'b0;
    @(negedge clk);

    // 6. ch3 code 2 -> 3 mid-burst
    c0[15:12] = 4'd2;
    f0[3] = 1'b1;
    p6 = {"1111000011110000", "1111111111111111",
          "0000111100001111", "00001111"};
    for (int j = 0; j < p6.len(); j++) begin
      @(negedge clk);
      chk("s6_led3", 32'(led0[3]), 32'(pbit(p6, j)));
      if (j == 2) c0[15:12] = 4'd3;
    end
    f0[3] = 1'b0;
    @(negedge clk);
    chk("s6_lat0", 32'(lat0), 32'h0);
    chk("s6_idle", 32'(led0), 32'hf);

    // 5. sticky latch on dut1 ch2
    c1[11:8] = 4'd0;
    f1[2] = 1'b1;
    @(negedge clk);
    chk("s5_set", 32'(lat1[2]), 32'h1);
    chk("s5_led0", 32'(led1[2]), 32'h1);
    f1[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_blink", 32'(led1[2]), 32'h0);
    chk("s5_hold", 32'(lat1[2]), 32'h1);
    chk("s5_any", 32'(any1), 32'h1);
    f1[2] = 1'b1;
    clr1 = 1'b1;
    @(negedge clk);
    chk("s5_setwin", 32'(lat1[2]), 32'h1);
    clr1 = 1'b0;
    f1[2] = 1'b0;
    @(negedge clk);
    chk("s5_keep", 32'(lat1[2]), 32'h1);
    clr1 = 1'b1;
    @(negedge clk);
    chk("s5_clr", 32'(lat1[2]), 32'h0);
    clr1 = 1'b0;
    @(negedge clk);
    chk("s5_led", 32'(led1[2]), 32'h1);
    chk("s5_anyoff", 32'(any1), 32'h0);

    // async reset mid-pattern
    f0[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_pre", 32'(led0), 32'he);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_led", 32'(led0), 32'h0);
    chk("ar_any", 32'(any0), 32'h0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
